// File: rtl/calc_seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states and status flag positions.
package calc_seq_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFin
    } state_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_DIV0  = 3;
    localparam int unsigned NUM_FLAGS  = 4;

endpackage

// File: rtl/calc_seq_alu_if.sv
// Command/result bundle between the command decoder (master) and the ALU (slave).
interface calc_seq_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic [1:0]             op;
    logic                   signed_mode;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   valid;
    logic [2*WIDTH-1:0]     result;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   zero;
    logic                   carry;
    logic                   ovf;
    logic                   div0;

    modport master (
        output start, op, signed_mode, a, b,
        input  busy, valid, result, quotient, remainder, zero, carry, ovf, div0
    );

    modport slave (
        input  start, op, signed_mode, a, b,
        output busy, valid, result, quotient, remainder, zero, carry, ovf, div0
    );

endinterface

// File: rtl/calc_restoring_div.sv
// Unsigned restoring divider, one quotient bit per step; the caller owns the iteration count.
module calc_restoring_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             step,
    input  logic             last,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic             done_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;

    // Dividend bits are shifted out of the quotient register as quotient bits shift in.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        fits    = shifted >= {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            done_q <= 1'b0;
        end else if (ld) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
            done_q <= 1'b0;
        end else if (step) begin
            if (fits) begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            done_q <= last;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/calc_seq_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB, iterative MUL/DIV over magnitudes with a final sign fix.
module calc_seq_alu
    import calc_seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    calc_seq_alu_if.slave bus
);
    localparam int unsigned      CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LastIter = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinVal   = {1'b1, {(WIDTH-1){1'b0}}};

    state_e               state;
    op_e                  op_q;
    logic                 sm_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 neg_main_q;
    logic                 neg_rem_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;

    logic                 busy_q;
    logic                 valid_q;
    logic [2*WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]     quot_q;
    logic [WIDTH-1:0]     rem_q;
    logic [NUM_FLAGS-1:0] flags_q;

    logic             accept;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        accept = bus.start && !busy_q;
        sign_a = bus.signed_mode && bus.a[WIDTH-1];
        sign_b = bus.signed_mode && bus.b[WIDTH-1];
        mag_a  = sign_a ? -bus.a : bus.a;
        mag_b  = sign_b ? -bus.b : bus.b;
    end

    logic             div_ld;
    logic             div_step;
    logic             div_last;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    // Loaded on every DIV accept so a stale done never survives into a divide-by-zero.
    assign div_ld   = accept && (bus.op == OP_DIV);
    assign div_step = (state == StDiv);
    assign div_last = (cnt_q == LastIter);

    calc_restoring_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .ld       (div_ld),
        .step     (div_step),
        .last     (div_last),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quotient (div_quo),
        .remainder(div_rem),
        .done     (div_done)
    );

    logic [WIDTH:0]       as_sum;
    logic [WIDTH:0]       as_diff;
    logic [WIDTH-1:0]     as_res;
    logic                 as_cout;
    logic                 as_ovf;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    logic [2*WIDTH-1:0]   fin_result;
    logic [WIDTH-1:0]     fin_quo;
    logic [WIDTH-1:0]     fin_rem;
    logic [NUM_FLAGS-1:0] fin_flags;

    always_comb begin
        as_sum  = {1'b0, a_q} + {1'b0, b_q};
        as_diff = {1'b0, a_q} - {1'b0, b_q};
        as_res  = (op_q == OP_SUB) ? as_diff[WIDTH-1:0] : as_sum[WIDTH-1:0];
        as_cout = (op_q == OP_SUB) ? as_diff[WIDTH] : as_sum[WIDTH];
        as_ovf  = ((op_q == OP_SUB) ? (a_q[WIDTH-1] != b_q[WIDTH-1])
                                    : (a_q[WIDTH-1] == b_q[WIDTH-1]))
                  && (as_res[WIDTH-1] != a_q[WIDTH-1]);
        prod    = neg_main_q ? -acc_q : acc_q;
        q_fix   = neg_main_q ? -div_quo : div_quo;
        r_fix   = neg_rem_q ? -div_rem : div_rem;

        fin_result = '0;
        fin_quo    = '0;
        fin_rem    = '0;
        fin_flags  = '0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                fin_result            = {{WIDTH{sm_q && as_res[WIDTH-1]}}, as_res};
                fin_flags[FLAG_ZERO]  = (as_res == '0);
                fin_flags[FLAG_CARRY] = !sm_q && as_cout;
                fin_flags[FLAG_OVF]   = sm_q && as_ovf;
            end
            OP_MUL: begin
                fin_result           = prod;
                fin_flags[FLAG_ZERO] = (prod == '0);
            end
            OP_DIV: begin
                if (div_done) begin
                    fin_quo             = q_fix;
                    fin_rem             = r_fix;
                    fin_flags[FLAG_OVF] = sm_q && (a_q == MinVal) && (b_q == '1);
                end else begin
                    fin_quo              = '1;
                    fin_rem              = a_q;
                    fin_flags[FLAG_DIV0] = 1'b1;
                end
                fin_result           = {fin_rem, fin_quo};
                fin_flags[FLAG_ZERO] = (fin_quo == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            op_q       <= OP_ADD;
            sm_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            flags_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        op_q       <= op_e'(bus.op);
                        sm_q       <= bus.signed_mode;
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        neg_main_q <= sign_a ^ sign_b;
                        neg_rem_q  <= sign_a;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        mcand_q    <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q   <= mag_b;
                        busy_q     <= 1'b1;
                        if (bus.op == OP_MUL) begin
                            state <= StMul;
                        end else if ((bus.op == OP_DIV) && (bus.b != '0)) begin
                            state <= StDiv;
                        end else begin
                            state <= StFin;
                        end
                    end
                end
                StMul: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state <= StFin;
                    end
                end
                StDiv: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state <= StFin;
                    end
                end
                StFin: begin
                    result_q <= fin_result;
                    quot_q   <= fin_quo;
                    rem_q    <= fin_rem;
                    flags_q  <= fin_flags;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.result    = result_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.zero      = flags_q[FLAG_ZERO];
    assign bus.carry     = flags_q[FLAG_CARRY];
    assign bus.ovf       = flags_q[FLAG_OVF];
    assign bus.div0      = flags_q[FLAG_DIV0];

endmodule

// File: tb/tb_calc_seq_alu.sv
// Directed vector table, handshake corner cases and a randomised comparison against an integer model.
module tb_calc_seq_alu;
    import calc_seq_alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    calc_seq_alu_if #(.WIDTH(8)) bus ();

    calc_seq_alu #(
        .WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic [7:0]  q;
        logic [7:0]  r;
        logic [3:0]  flags;  // {div0, ovf, carry, zero}
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] act_flags();
        return {bus.div0, bus.ovf, bus.carry, bus.zero};
    endfunction

    task automatic launch(input logic [1:0] o, input logic s, input logic [7:0] x,
                          input logic [7:0] y);
        bus.start       = 1'b1;
        bus.op          = o;
        bus.signed_mode = s;
        bus.a           = x;
        bus.b           = y;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: valid never seen, got busy=%0b expected valid=1", bus.busy);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic s, input logic [7:0] x,
                          input logic [7:0] y, output int lat);
        @(negedge clk);
        launch(o, s, x, y);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_valid(lat);
    endtask

    function automatic void model(input logic [1:0] o, input logic s, input logic [7:0] x,
                                  input logic [7:0] y, output logic [15:0] r,
                                  output logic [7:0] q, output logic [7:0] rm,
                                  output logic [3:0] f);
        int sx, sy, t;
        logic [7:0] lo;
        sx = s ? int'($signed(x)) : int'(x);
        sy = s ? int'($signed(y)) : int'(y);
        r  = '0;
        q  = '0;
        rm = '0;
        f  = '0;
        case (o)
            2'd0, 2'd1: begin
                t  = (o == 2'd0) ? sx + sy : sx - sy;
                lo = t[7:0];
                r  = s ? {{8{lo[7]}}, lo} : {8'h00, lo};
                f[0] = (lo == 8'h00);
                if (s) f[2] = (t > 127) || (t < -128);
                else   f[1] = (t > 255) || (t < 0);
            end
            2'd2: begin
                t    = sx * sy;
                r    = t[15:0];
                f[0] = (r == 16'h0000);
            end
            default: begin
                if (y == 8'h00) begin
                    q    = 8'hFF;
                    rm   = x;
                    f[3] = 1'b1;
                end else if (s && x == 8'h80 && y == 8'hFF) begin
                    q    = 8'h80;
                    rm   = 8'h00;
                    f[2] = 1'b1;
                end else begin
                    t  = sx / sy;
                    q  = t[7:0];
                    t  = sx % sy;
                    rm = t[7:0];
                end
                r    = {rm, q};
                f[0] = (q == 8'h00);
            end
        endcase
    endfunction

    initial begin
        int lat;
        logic saw;
        logic [1:0]  ro;
        logic        rs;
        logic [7:0]  rx, ry, eq, er;
        logic [15:0] eres;
        logic [3:0]  ef;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        launch(OP_ADD, 1'b0, 8'h00, 8'h00);
        bus.start = 1'b0;

        vecs[0]  = '{OP_ADD, 1'b0, 8'hC8, 8'h64, 16'h002C, 8'h00, 8'h00, 4'b0010, 1};
        vecs[1]  = '{OP_SUB, 1'b1, 8'h64, 8'h9C, 16'hFFC8, 8'h00, 8'h00, 4'b0100, 1};
        vecs[2]  = '{OP_SUB, 1'b0, 8'h64, 8'h37, 16'h002D, 8'h00, 8'h00, 4'b0000, 1};
        vecs[3]  = '{OP_SUB, 1'b0, 8'h05, 8'h07, 16'h00FE, 8'h00, 8'h00, 4'b0010, 1};
        vecs[4]  = '{OP_ADD, 1'b1, 8'h7F, 8'h01, 16'hFF80, 8'h00, 8'h00, 4'b0100, 1};
        vecs[5]  = '{OP_ADD, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h00, 4'b0001, 1};
        vecs[6]  = '{OP_ADD, 1'b0, 8'h80, 8'h80, 16'h0000, 8'h00, 8'h00, 4'b0011, 1};
        vecs[7]  = '{OP_MUL, 1'b1, 8'hF4, 8'h0B, 16'hFF7C, 8'h00, 8'h00, 4'b0000, 9};
        vecs[8]  = '{OP_MUL, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8'h00, 8'h00, 4'b0000, 9};
        vecs[9]  = '{OP_MUL, 1'b1, 8'h80, 8'h80, 16'h4000, 8'h00, 8'h00, 4'b0000, 9};
        vecs[10] = '{OP_MUL, 1'b0, 8'h00, 8'h4D, 16'h0000, 8'h00, 8'h00, 4'b0001, 9};
        vecs[11] = '{OP_DIV, 1'b0, 8'hC8, 8'h0D, 16'h050F, 8'h0F, 8'h05, 4'b0000, 9};
        vecs[12] = '{OP_DIV, 1'b1, 8'hF9, 8'h02, 16'hFFFD, 8'hFD, 8'hFF, 4'b0000, 9};
        vecs[13] = '{OP_DIV, 1'b1, 8'h80, 8'hFF, 16'h0080, 8'h80, 8'h00, 4'b0100, 9};
        vecs[14] = '{OP_DIV, 1'b0, 8'h25, 8'h00, 16'h25FF, 8'hFF, 8'h25, 4'b1000, 1};
        vecs[15] = '{OP_DIV, 1'b0, 8'h05, 8'h09, 16'h0500, 8'h00, 8'h05, 4'b0001, 9};
        vecs[16] = '{OP_DIV, 1'b1, 8'h07, 8'hFE, 16'h01FD, 8'hFD, 8'h01, 4'b0000, 9};
        vecs[17] = '{OP_DIV, 1'b0, 8'hFF, 8'hC8, 16'h3701, 8'h01, 8'h37, 4'b0000, 9};
        vecs[18] = '{OP_MUL, 1'b1, 8'h7F, 8'hFF, 16'hFF81, 8'h00, 8'h00, 4'b0000, 9};
        vecs[19] = '{OP_DIV, 1'b1, 8'h80, 8'h00, 16'h80FF, 8'hFF, 8'h80, 4'b1000, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy/valid", {bus.busy, bus.valid}, 2'b00);
        chk("reset result", bus.result, 16'h0000);
        chk("reset q/r/flags", {bus.quotient, bus.remainder, act_flags()}, 20'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d result", i), bus.result, vecs[i].res);
            chk($sformatf("vec%0d quotient", i), bus.quotient, vecs[i].q);
            chk($sformatf("vec%0d remainder", i), bus.remainder, vecs[i].r);
            chk($sformatf("vec%0d flags", i), act_flags(), vecs[i].flags);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d busy at valid", i), bus.busy, 1'b0);
        end

        // Start pulsed mid-MUL must be ignored and outputs must hold.
        run_op(OP_ADD, 1'b0, 8'h03, 8'h04, lat);
        @(negedge clk);
        launch(OP_MUL, 1'b0, 8'h03, 8'h05);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("accept busy", bus.busy, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        launch(OP_ADD, 1'b0, 8'h01, 8'h01);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ignored start busy/valid", {bus.busy, bus.valid}, 2'b10);
        chk("outputs held while busy", bus.result, 16'h0007);
        wait_valid(lat);
        chk("mul after ignored start", bus.result, 16'h000F);
        chk("mul latency after ignored start", lat, 6);
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            saw = saw | bus.valid | bus.busy;
        end
        chk("no extra op from ignored start", saw, 1'b0);

        // Reset during the fourth MUL cycle aborts without a valid.
        @(negedge clk);
        launch(OP_MUL, 1'b0, 8'h09, 8'h09);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy/valid", {bus.busy, bus.valid}, 2'b00);
        chk("abort result cleared", bus.result, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            saw = saw | bus.valid;
        end
        chk("no valid after abort", saw, 1'b0);
        run_op(OP_ADD, 1'b0, 8'h02, 8'h03, lat);
        chk("recovery after abort", bus.result, 16'h0005);

        // Back-to-back: new start presented in the valid cycle.
        run_op(OP_ADD, 1'b0, 8'h0A, 8'h14, lat);
        chk("b2b first result", bus.result, 16'h001E);
        launch(OP_SUB, 1'b0, 8'h32, 8'h09);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b accepted", bus.busy, 1'b1);
        wait_valid(lat);
        chk("b2b sub result", bus.result, 16'h0029);
        chk("b2b sub latency", lat, 1);
        launch(OP_MUL, 1'b1, 8'h06, 8'hF9);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_valid(lat);
        chk("b2b mul result", bus.result, 16'hFFD6);
        chk("b2b mul latency", lat, 9);

        for (int n = 0; n < 1000; n++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) ry = 8'h00;
            if ($urandom_range(0, 31) == 0) begin
                rx = 8'h80;
                ry = 8'hFF;
            end
            model(ro, rs, rx, ry, eres, eq, er, ef);
            run_op(ro, rs, rx, ry, lat);
            chk($sformatf("rand%0d op=%0d s=%0b a=%0h b=%0h", n, ro, rs, rx, ry),
                {bus.result, bus.quotient, bus.remainder, act_flags()},
                {eres, eq, er, ef});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
